// File: rtl/farm_vehicle_detector.sv
// Farm-road sensor front end: debounces the vehicle loop, keeps a queue count,
// and shapes the farm-road request S around max-green and highway hold-off limits.
module farm_vehicle_detector #(
   parameter int DEBOUNCE      = 3,
   parameter int QW            = 4,
   parameter int DEPART_CYCLES = 2,
   parameter int MAX_GREEN     = 16,
   parameter int MIN_HWY_GREEN = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          loop_raw,
   input  logic [2:0]    light_farm,
   output logic          S,
   output logic [QW-1:0] queue_count,
   output logic          overflow,
   output logic          timeout,
   output logic          enc_err
);

   localparam int DBW = $clog2(DEBOUNCE + 1);
   localparam int DPW = $clog2(DEPART_CYCLES + 1);
   localparam int GW  = $clog2(MAX_GREEN + 1);
   localparam int HW  = $clog2(MIN_HWY_GREEN + 1);
   localparam logic [QW-1:0] Q_MAX = '1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQUEST,
      ST_SERVE,
      ST_RELEASE,
      ST_HOLDOFF
   } state_t;

   state_t state, state_next;

   logic           sync1, sync2, deb_level, deb_prev;
   logic [DBW-1:0] deb_cnt;
   logic [DPW-1:0] dep_cnt;
   logic [GW-1:0]  green_cnt;
   logic [HW-1:0]  hold_cnt;
   logic           arrival, departure, dep_active;
   logic           farm_green, farm_red, enc_ok;
   logic           timeout_next;

   assign farm_green = (light_farm == 3'b001);
   assign farm_red   = (light_farm == 3'b100);
   assign enc_ok     = farm_green || farm_red || (light_farm == 3'b010);

   assign arrival    = deb_level && !deb_prev;
   assign dep_active = farm_green && (queue_count != '0);
   assign departure  = dep_active && (dep_cnt == DPW'(DEPART_CYCLES - 1));

   // Input path: synchronizer, then a level only accepted after DEBOUNCE stable mismatches.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         deb_level <= 1'b0;
         deb_prev  <= 1'b0;
         deb_cnt   <= '0;
      end else begin
         sync1    <= loop_raw;
         sync2    <= sync1;
         deb_prev <= deb_level;
         if (sync2 != deb_level) begin
            if (deb_cnt == DBW'(DEBOUNCE - 1)) begin
               deb_level <= sync2;
               deb_cnt   <= '0;
            end else begin
               deb_cnt <= deb_cnt + DBW'(1);
            end
         end else begin
            deb_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dep_cnt     <= '0;
         queue_count <= '0;
         overflow    <= 1'b0;
      end else begin
         if (!dep_active || departure) dep_cnt <= '0;
         else                          dep_cnt <= dep_cnt + DPW'(1);
         // Simultaneous arrival and departure cancel out.
         case ({arrival, departure})
            2'b10: begin
               if (queue_count == Q_MAX) overflow <= 1'b1;
               else                      queue_count <= queue_count + QW'(1);
            end
            2'b01:   queue_count <= queue_count - QW'(1);
            default: queue_count <= queue_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         green_cnt <= '0;
         hold_cnt  <= '0;
         timeout   <= 1'b0;
         enc_err   <= 1'b0;
      end else begin
         state     <= state_next;
         green_cnt <= (state == ST_SERVE)   ? green_cnt + GW'(1) : '0;
         hold_cnt  <= (state == ST_HOLDOFF) ? hold_cnt + HW'(1)  : '0;
         timeout   <= timeout_next;
         enc_err   <= !enc_ok;
      end
   end

   always_comb begin
      state_next   = state;
      timeout_next = 1'b0;
      case (state)
         ST_IDLE:    if (queue_count != '0) state_next = ST_REQUEST;
         ST_REQUEST: if (farm_green) state_next = ST_SERVE;
         ST_SERVE: begin
            if (queue_count == '0) begin
               state_next = ST_RELEASE;
            end else if (green_cnt == GW'(MAX_GREEN - 1)) begin
               state_next   = ST_RELEASE;
               timeout_next = 1'b1;
            end else if (!farm_green) begin
               state_next = ST_RELEASE;
            end
         end
         ST_RELEASE: if (farm_red) state_next = ST_HOLDOFF;
         ST_HOLDOFF: begin
            if (hold_cnt == HW'(MIN_HWY_GREEN - 1))
               state_next = (queue_count != '0) ? ST_REQUEST : ST_IDLE;
         end
         default:    state_next = ST_IDLE;
      endcase
   end

   // Request is a pure decode of the state register.
   assign S = (state == ST_REQUEST) || (state == ST_SERVE);

endmodule

// File: doc/farm_vehicle_detector.md
Name: farm_vehicle_detector

Overview:
- Sensor front end for the highway/farm-road intersection controller. Drives the controller's farm-road request input `S` and consumes its `light_farm` output.
- Debounces a raw inductive-loop input and counts vehicles queued on the farm road.
- Retires queued vehicles while the farm light is green, and shapes `S` with a maximum-green timeout and a minimum highway-green hold-off.

Parameters:
- DEBOUNCE, 3: consecutive cycles the synchronized loop must differ from the debounced value before the debounced value changes.
- QW, 4: width of the vehicle queue counter. The counter saturates at 2^QW-1.
- DEPART_CYCLES, 2: farm-green cycles per vehicle departure.
- MAX_GREEN, 16: maximum cycles `S` is held in SERVE.
- MIN_HWY_GREEN, 8: cycles `S` is forced low after the farm light returns to red.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- loop_raw  in  1  asynchronous raw vehicle-loop level.
- light_farm  in  3  farm light from the controller: 001 green, 010 yellow, 100 red.
- S  out  1  farm-road request to the controller.
- queue_count  out  QW  current number of queued vehicles.
- overflow  out  1  sticky; set on an arrival while the queue is saturated.
- timeout  out  1  one-cycle pulse when MAX_GREEN ends SERVE with vehicles still queued.
- enc_err  out  1  registered flag, high the cycle after `light_farm` is sampled outside {001,010,100}.

Behaviour:
- Reset (rst=1 at a rising edge) applies regardless of activity:
  - Outputs: S=0, queue_count=0, overflow=0, timeout=0, enc_err=0.
  - Internal: sync flops 0, debounced level 0, all counters 0, state IDLE.
- Input path:
  - 2-flop synchronizer on `loop_raw`.
  - Debounce counter increments while the synced value differs from the debounced value. It clears when they match.
  - The debounced value updates when the count reaches DEBOUNCE.
  - arrival = rising edge of the debounced value (one cycle).
  - Latency: queue_count increments on the (DEBOUNCE+3)th edge, counting the first edge that samples loop_raw=1 as edge 1. This is edge 6 at default.
  - Glitches shorter than DEBOUNCE synced cycles produce no arrival.
- Departure path:
  - farm_green = (light_farm==001).
  - Depart timer counts while farm_green and queue_count>0. It clears whenever either condition is false.
  - A departure fires when the timer reaches DEPART_CYCLES; the timer then restarts at 0.
  - No departure at queue_count=0.
- Queue update:
  - Arrival only: +1. Departure only: -1. Both in the same cycle: unchanged.
  - Arrival at 2^QW-1 without a departure: value held, overflow set. overflow clears only on rst.
- FSM (S decoded from the state register only; no combinational path from inputs):
  - IDLE (S=0): queue_count>0 -> REQUEST.
  - REQUEST (S=1): farm_green -> SERVE; green_cnt cleared.
  - SERVE (S=1):
    - green_cnt increments each cycle.
    - Queue becomes 0 (registered value reads 0) -> RELEASE.
    - Otherwise green_cnt==MAX_GREEN-1 -> RELEASE with timeout pulsed for one cycle.
    - Light leaving green unexpectedly -> RELEASE.
  - RELEASE (S=0): light_farm==100 -> HOLDOFF; hold_cnt cleared.
  - HOLDOFF (S=0): hold_cnt increments. At MIN_HWY_GREEN-1: queue_count>0 -> REQUEST, else IDLE.
- Arrivals are counted in every state. A queue becoming non-zero during RELEASE or HOLDOFF does not raise S early.
- Illegal light_farm encoding:
  - enc_err pulses for that cycle.
  - Treated as not green and not red. FSM holds in RELEASE/HOLDOFF; SERVE exits to RELEASE.
- A mid-operation reset abandons any in-progress debounce, departure or hold-off. There is no residual pulse on the following cycle.

Test Plan:
- Reset then one clean arrival: rst high 2 cycles; loop_raw=1 held 10 cycles, light_farm=100 -> queue_count 0->1 at edge 6; S=1 one edge later; overflow, timeout and enc_err stay 0.
- Glitch rejection: loop_raw high for 2 cycles, then low -> queue_count stays 0 and S stays 0.
- Service and release: queue_count=3, S=1; drive light_farm=001 -> departures every 2 cycles, queue reaches 0 after 6 green cycles, S falls. Drive light_farm=010 then 100 -> S held 0 for 8 cycles. A new arrival during hold-off makes S rise exactly at hold-off end.
- Timeout: queue_count=15, light_farm=001 -> S falls after 16 SERVE cycles with timeout a one-cycle pulse; queue_count=7 at that point.
- Saturation and simultaneity: queue_count=15, one more arrival -> queue_count stays 15, overflow=1 sticky. An arrival coincident with a departure leaves the count unchanged.
- Illegal encoding and reset mid-SERVE: light_farm=011 for one cycle in SERVE -> enc_err=1 next cycle and FSM goes to RELEASE. rst asserted mid-SERVE -> all outputs 0 on the next edge.
